// File: rtl/ct_spsram_256x23_ctrl.sv
// Single-port SRAM controller: full-array init sweep plus round-robin read/write
// arbitration onto one port with a one-cycle read return.
module ct_spsram_256x23_ctrl #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 23,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  inv_all_req,
    output logic                  busy,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_data_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_gnt,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    typedef enum logic {INIT, IDLE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                  state, next_state;
    logic [ADDR_WIDTH-1:0]   init_cnt, init_cnt_nxt;
    logic                    prio, prio_nxt;
    logic                    busy_int, rd_gnt_int, wr_gnt_int;
    logic                    cen_int, gwen_int;
    logic [DATA_WIDTH-1:0]   wen_int, d_int;
    logic [ADDR_WIDTH-1:0]   a_int;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state       <= INIT;
            init_cnt    <= '0;
            prio        <= 1'b0;
            rd_data_vld <= 1'b0;
        end else begin
            state       <= next_state;
            init_cnt    <= init_cnt_nxt;
            prio        <= prio_nxt;
            rd_data_vld <= rd_gnt;
        end
    end

    // prio=0 favours the read side when both requesters collide
    always_comb begin
        next_state   = state;
        init_cnt_nxt = init_cnt;
        prio_nxt     = prio;
        busy_int     = 1'b0;
        rd_gnt_int   = 1'b0;
        wr_gnt_int   = 1'b0;
        cen_int      = 1'b1;
        gwen_int     = 1'b1;
        wen_int      = '1;
        a_int        = '0;
        d_int        = '0;
        case (state)
            INIT: begin
                busy_int     = 1'b1;
                cen_int      = 1'b0;
                gwen_int     = 1'b0;
                wen_int      = '0;
                a_int        = init_cnt;
                d_int        = INIT_VAL;
                init_cnt_nxt = init_cnt + 1'b1;
                if (init_cnt == LAST_ADDR) next_state = IDLE;
            end
            IDLE: begin
                if (inv_all_req) begin
                    next_state   = INIT;
                    init_cnt_nxt = '0;
                end else if (rd_req && wr_req) begin
                    prio_nxt   = ~prio;
                    rd_gnt_int = ~prio;
                    wr_gnt_int = prio;
                end else begin
                    rd_gnt_int = rd_req;
                    wr_gnt_int = wr_req;
                end
                if (rd_gnt_int) begin
                    cen_int = 1'b0;
                    a_int   = rd_addr;
                end else if (wr_gnt_int) begin
                    cen_int  = 1'b0;
                    gwen_int = 1'b0;
                    wen_int  = '0;
                    a_int    = wr_addr;
                    d_int    = wr_data;
                end
            end
            default: next_state = INIT;
        endcase
    end

    // State flops sit in INIT during reset, so the port is forced idle to avoid writes
    assign busy      = busy_int | ~cpurst_b;
    assign rd_gnt    = rd_gnt_int & cpurst_b;
    assign wr_gnt    = wr_gnt_int & cpurst_b;
    assign sram_cen  = cen_int | ~cpurst_b;
    assign sram_gwen = gwen_int | ~cpurst_b;
    assign sram_wen  = wen_int | {DATA_WIDTH{~cpurst_b}};
    assign sram_a    = cpurst_b ? a_int : '0;
    assign sram_d    = cpurst_b ? d_int : '0;
    assign rd_data   = sram_q;

endmodule

// File: tb/tb_ct_spsram_256x23_ctrl.sv
// Directed bench for ct_spsram_256x23_ctrl with a behavioural 256x23 SRAM model
// attached to the macro-side port.
module tb_ct_spsram_256x23_ctrl;

    logic        forever_cpuclk = 1'b0;
    logic        cpurst_b;
    logic        inv_all_req;
    logic        busy;
    logic        rd_req;
    logic [7:0]  rd_addr;
    logic        rd_gnt;
    logic        rd_data_vld;
    logic [22:0] rd_data;
    logic        wr_req;
    logic [7:0]  wr_addr;
    logic [22:0] wr_data;
    logic        wr_gnt;
    logic [7:0]  sram_a;
    logic        sram_cen;
    logic        sram_gwen;
    logic [22:0] sram_wen;
    logic [22:0] sram_d;
    logic [22:0] sram_q = '0;

    logic [22:0] mem [256];
    int          assert_cnt = 0;
    int          fail_cnt   = 0;

    always #5 forever_cpuclk = ~forever_cpuclk;

    ct_spsram_256x23_ctrl dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .inv_all_req    (inv_all_req),
        .busy           (busy),
        .rd_req         (rd_req),
        .rd_addr        (rd_addr),
        .rd_gnt         (rd_gnt),
        .rd_data_vld    (rd_data_vld),
        .rd_data        (rd_data),
        .wr_req         (wr_req),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_gnt         (wr_gnt),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_d         (sram_d),
        .sram_q         (sram_q)
    );

    // Macro model: bit-masked write, registered read data one cycle after a read
    always @(posedge forever_cpuclk) begin
        if (!sram_cen) begin
            if (!sram_gwen)
                mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else
                sram_q <= mem[sram_a];
        end
    end

    task automatic apply_stimulus(input logic inv, input logic rq, input logic [7:0] ra,
                                  input logic wq, input logic [7:0] wa, input logic [22:0] wd);
        inv_all_req = inv;
        rd_req      = rq;
        rd_addr     = ra;
        wr_req      = wq;
        wr_addr     = wa;
        wr_data     = wd;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        assert_cnt++;
        assert (observed === expected)
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Entered at negedge+1 of sweep cycle 0; leaves at negedge+1 of the first IDLE cycle
    task automatic check_sweep(input int pulse_at, input logic hold_rd);
        for (int i = 0; i < 256; i++) begin
            check_output("sweep_cycle",
                         {27'd0, busy, sram_cen, sram_gwen, |sram_wen, rd_gnt, wr_gnt, sram_a, sram_d},
                         {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'(i), 23'd0});
            @(negedge forever_cpuclk);
            apply_stimulus((i + 1) == pulse_at, hold_rd, rd_addr, 1'b0, 8'h00, 23'h0);
            #1;
        end
        check_output("sweep_done_busy", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        cpurst_b = 1'b0;
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 23'h0);
        repeat (2) @(negedge forever_cpuclk);
        #1;
        $display("[TB] reset state");
        check_output("rst_busy_gnt_vld", {60'd0, busy, rd_gnt, wr_gnt, rd_data_vld}, 64'h8);
        check_output("rst_cen_gwen_wen", {39'd0, sram_cen, sram_gwen, sram_wen},
                     {39'd0, 2'b11, 23'h7FFFFF});
        check_output("rst_a_d", {33'd0, sram_a, sram_d}, 64'd0);

        $display("[TB] initial sweep");
        @(negedge forever_cpuclk);
        cpurst_b = 1'b1;
        #1;
        check_sweep(-1, 1'b0);

        $display("[TB] write then read 0x12");
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'h12, 23'h5A5A5A);
        #1;
        check_output("wr_gnt", {62'd0, rd_gnt, wr_gnt}, 64'h1);
        check_output("wr_port", {39'd0, sram_cen, sram_gwen, sram_wen}, 64'd0);
        check_output("wr_a_d", {33'd0, sram_a, sram_d}, {33'd0, 8'h12, 23'h5A5A5A});
        @(negedge forever_cpuclk);
        apply_stimulus(1'b0, 1'b1, 8'h12, 1'b0, 8'h00, 23'h0);
        #1;
        check_output("rd_gnt", {62'd0, rd_gnt, wr_gnt}, 64'h2);
        check_output("rd_port", {31'd0, sram_cen, sram_gwen, sram_wen, sram_a},
                     {31'd0, 2'b01, 23'h7FFFFF, 8'h12});
        @(negedge forever_cpuclk);
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 23'h0);
        #1;
        check_output("rd_return", {40'd0, rd_data_vld, rd_data}, {40'd0, 1'b1, 23'h5A5A5A});
        check_output("idle_port", {31'd0, sram_cen, sram_gwen, sram_wen, sram_a},
                     {31'd0, 2'b11, 23'h7FFFFF, 8'h00});

        $display("[TB] round-robin with both requesting");
        for (int c = 0; c < 4; c++) begin
            @(negedge forever_cpuclk);
            apply_stimulus(1'b0, 1'b1, 8'h12, 1'b1, 8'h20, 23'h111111);
            #1;
            check_output("rr_grant", {62'd0, rd_gnt, wr_gnt}, (c % 2 == 0) ? 64'h2 : 64'h1);
            if (c == 1)
                check_output("rr_rd_return", {40'd0, rd_data_vld, rd_data}, {40'd0, 1'b1, 23'h5A5A5A});
        end

        $display("[TB] inv_all_req beats rd_req");
        @(negedge forever_cpuclk);
        apply_stimulus(1'b1, 1'b1, 8'h12, 1'b0, 8'h00, 23'h0);
        #1;
        check_output("inv_no_gnt", {61'd0, busy, rd_gnt, sram_cen}, 64'h1);
        @(negedge forever_cpuclk);
        apply_stimulus(1'b0, 1'b1, 8'h12, 1'b0, 8'h00, 23'h0);
        #1;
        check_sweep(-1, 1'b1);
        check_output("post_sweep_rd_gnt", {63'd0, rd_gnt}, 64'h1);
        @(negedge forever_cpuclk);
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 23'h0);
        #1;
        check_output("swept_rd_return", {40'd0, rd_data_vld, rd_data}, {40'd0, 1'b1, 23'h0});

        $display("[TB] reset mid-sweep");
        @(negedge forever_cpuclk);
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 23'h0);
        @(negedge forever_cpuclk);
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 23'h0);
        repeat (100) @(negedge forever_cpuclk);
        #1;
        check_output("sweep_at_100", {55'd0, busy, sram_a}, {55'd0, 1'b1, 8'd100});
        cpurst_b = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            check_output("midrst_port", {29'd0, busy, rd_data_vld, sram_cen, sram_gwen, sram_wen, sram_a},
                         {29'd0, 1'b1, 1'b0, 2'b11, 23'h7FFFFF, 8'h00});
            @(negedge forever_cpuclk);
            #1;
        end
        cpurst_b = 1'b1;
        #1;
        check_sweep(-1, 1'b0);

        $display("[TB] inv_all_req ignored during sweep");
        @(negedge forever_cpuclk);
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 23'h0);
        @(negedge forever_cpuclk);
        apply_stimulus(1'b0, 1'b1, 8'h20, 1'b0, 8'h00, 23'h0);
        #1;
        check_sweep(50, 1'b1);
        check_output("stalled_rd_gnt", {63'd0, rd_gnt}, 64'h1);
        @(negedge forever_cpuclk);
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 23'h0);
        #1;
        check_output("stalled_rd_return", {40'd0, rd_data_vld, rd_data}, {40'd0, 1'b1, 23'h0});

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
